// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer.
// Holds the ALU select encodings, the macro-op opcodes and the status-flag bit positions.
// Also holds the sequencer FSM state type and the opcode-to-ALU-select mapping.
package alu_pkg;

  // ALU select encodings
  localparam logic [2:0] ADD   = 3'd0;
  localparam logic [2:0] SUB   = 3'd1;
  localparam logic [2:0] SUB_R = 3'd2;
  localparam logic [2:0] INC   = 3'd3;
  localparam logic [2:0] AND   = 3'd4;
  localparam logic [2:0] OR    = 3'd5;
  localparam logic [2:0] XOR   = 3'd6;
  localparam logic [2:0] EQ    = 3'd7;

  // Macro opcodes layered on top of the native 0-7 selects
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;
  localparam logic [3:0] OP_ADC = 4'd10;

  // Bit positions inside a {C,Z,N} flag vector
  localparam int unsigned C_FLAG = 2;
  localparam int unsigned Z_FLAG = 1;
  localparam int unsigned N_FLAG = 0;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StMulLoop,
    StAdcFix,
    StResp
  } seq_state_e;

  // ALU select used in the EXEC cycle for a legal, non-MUL opcode
  function automatic logic [2:0] op_to_select(logic [3:0] op);
    logic [2:0] sel;
    sel = op[2:0];
    if (op == OP_CMP) sel = SUB;
    if (op == OP_ADC) sel = ADD;
    return sel;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response bus between the issue stage and the ALU operation sequencer.
// master: issue side (drives requests, accepts responses).
// slave : sequencer side.
// Request : req_valid, req_ready, req_op[3:0], req_a[W-1:0], req_b[W-1:0].
// Response: rsp_valid, rsp_ready, rsp_result[W-1:0], rsp_flags[2:0] ({C,Z,N}), rsp_err.
interface alu_op_sequencer_if #(
  parameter int unsigned W = 24
);
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic [2:0]   rsp_flags;
  logic         rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );
endinterface

// File: rtl/alu_mul_ctrl.sv
// Shift-add multiplier state for the MUL macro-op; the additions run on the external ALU.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 load acc=0, mcand=a, mplier=b, count=0
//   busy                  sequencer is in the MUL loop this cycle
//   a, b                  multiplicand / multiplier at start
//   alu_result, alu_c     ALU sum acc+mcand and its carry
//   acc_next, mcand_next  next-state values, used to pre-load the ALU operand registers
//   c_sticky_next         OR of carries of all accumulated additions
//   done                  last iteration happens this cycle
module alu_mul_ctrl #(
  parameter int unsigned W     = 24,
  parameter int unsigned CNT_W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         busy,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] alu_result,
  input  logic         alu_c,
  output logic [W-1:0] acc_next,
  output logic [W-1:0] mcand_next,
  output logic         c_sticky_next,
  output logic         done
);

  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             c_sticky_q, c_sticky_d;

  always_comb begin
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    count_d    = count_q;
    c_sticky_d = c_sticky_q;
    if (start) begin
      acc_d      = '0;
      mcand_d    = a;
      mplier_d   = b;
      count_d    = '0;
      c_sticky_d = 1'b0;
    end else if (busy) begin
      count_d = count_q + 1'b1;
      // Step 0 only primes the ALU operand registers; steps 1..W are the real iterations.
      if (count_q != '0) begin
        if (mplier_q[0]) begin
          acc_d      = alu_result;
          c_sticky_d = c_sticky_q | alu_c;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
    end
  end

  assign acc_next      = acc_d;
  assign mcand_next    = mcand_d;
  assign c_sticky_next = c_sticky_d;
  assign done          = busy && (count_q == CNT_W'(W));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      count_q    <= '0;
      c_sticky_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      count_q    <= count_d;
      c_sticky_q <= c_sticky_d;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Control end of the external W-bit ALU: accepts requests, drives ALU operands, captures the
// combinational result/flags and returns a response. Adds MUL, CMP and ADC macro-ops and owns
// the architectural {C,Z,N} status register.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   bus (slave)                request/response handshake
//   alu_a, alu_b, alu_select   registered ALU drive; hold their value when idle
//   alu_carry_in               architectural C flag
//   alu_result, alu_flags      combinational ALU outputs, same cycle
//   stat_flags                 architectural {C,Z,N}
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned W     = 24,
  parameter int unsigned CNT_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  alu_op_sequencer_if.slave   bus,
  output logic [W-1:0]        alu_a,
  output logic [W-1:0]        alu_b,
  output logic [2:0]          alu_select,
  output logic                alu_carry_in,
  input  logic [W-1:0]        alu_result,
  input  logic [2:0]          alu_flags,
  output logic [2:0]          stat_flags
);

  seq_state_e   state_q, state_d;
  logic [3:0]   op_q, op_d;
  logic         adc_fix_q, adc_fix_d;
  logic [W-1:0] alu_a_q, alu_a_d;
  logic [W-1:0] alu_b_q, alu_b_d;
  logic [2:0]   alu_sel_q, alu_sel_d;
  logic [W-1:0] rsp_result_q, rsp_result_d;
  logic [2:0]   rsp_flags_q, rsp_flags_d;
  logic         rsp_err_q, rsp_err_d;
  logic [2:0]   stat_q, stat_d;

  logic         mul_start;
  logic         mul_busy;
  logic         mul_done;
  logic [W-1:0] mul_acc_next;
  logic [W-1:0] mul_mcand_next;
  logic         mul_c_next;

  assign mul_busy = (state_q == StMulLoop);

  alu_mul_ctrl #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_mul_ctrl (
    .clk           (clk),
    .reset         (reset),
    .start         (mul_start),
    .busy          (mul_busy),
    .a             (bus.req_a),
    .b             (bus.req_b),
    .alu_result    (alu_result),
    .alu_c         (alu_flags[C_FLAG]),
    .acc_next      (mul_acc_next),
    .mcand_next    (mul_mcand_next),
    .c_sticky_next (mul_c_next),
    .done          (mul_done)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    adc_fix_d    = adc_fix_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    stat_d       = stat_q;
    mul_start    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          op_d      = bus.req_op;
          // ADC needs the increment fix-up only when carry is set at accept time
          adc_fix_d = (bus.req_op == OP_ADC) && stat_q[C_FLAG];
          if (bus.req_op == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = StMulLoop;
          end else if (bus.req_op > OP_ADC) begin
            rsp_result_d = '0;
            rsp_flags_d  = '0;
            rsp_err_d    = 1'b1;
            state_d      = StResp;
          end else begin
            alu_a_d   = bus.req_a;
            alu_b_d   = bus.req_b;
            alu_sel_d = op_to_select(bus.req_op);
            state_d   = StExec;
          end
        end
      end
      StExec: begin
        rsp_err_d    = 1'b0;
        rsp_flags_d  = alu_flags;
        rsp_result_d = (op_q == OP_CMP) ? '0 : alu_result;
        if (adc_fix_q) begin
          alu_a_d   = alu_result;
          alu_sel_d = INC;
          state_d   = StAdcFix;
        end else begin
          state_d = StResp;
        end
      end
      StAdcFix: begin
        rsp_result_d         = alu_result;
        rsp_flags_d          = alu_flags;
        rsp_flags_d[C_FLAG]  = alu_flags[C_FLAG] | rsp_flags_q[C_FLAG];
        state_d              = StResp;
      end
      StMulLoop: begin
        // Operand registers track the multiplier's next state so the ALU sees acc+mcand each cycle
        alu_a_d   = mul_acc_next;
        alu_b_d   = mul_mcand_next;
        alu_sel_d = ADD;
        if (mul_done) begin
          rsp_result_d = mul_acc_next;
          rsp_flags_d  = {mul_c_next, (mul_acc_next == '0), mul_acc_next[W-1]};
          rsp_err_d    = 1'b0;
          state_d      = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          if (!rsp_err_q) stat_d = rsp_flags_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      op_q         <= '0;
      adc_fix_q    <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
      stat_q       <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      adc_fix_q    <= adc_fix_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
      stat_q       <= stat_d;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_err    = rsp_err_q;

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_select   = alu_sel_q;
  assign alu_carry_in = stat_q[C_FLAG];
  assign stat_flags   = stat_q;

endmodule
